// File: rtl/block_mean_calc.sv
// Per-block luma averaging for local dimming: accumulates each block of a block row,
// then streams one saturated 8-bit mean per block through a two-stage multiply pipeline.
module block_mean_calc #(
    parameter int H_BLOCKS = 8,
    parameter int V_BLOCKS = 5,
    parameter int BLK_W    = 160,
    parameter int BLK_H    = 144,
    parameter int SUM_W    = 23,
    parameter int RECIP    = 11651,
    parameter int SHIFT    = 28
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       vs_in,
    input  logic       de_in,
    input  logic [7:0] y_in,
    output logic [7:0] block_mean,
    output logic       data_vaild,
    output logic [5:0] block_v_cnt
);
    localparam int PX_W   = $clog2(BLK_W + 1);
    localparam int LN_W   = $clog2(BLK_H + 1);
    localparam int HB_W   = $clog2(H_BLOCKS + 1);
    localparam int PROD_W = SUM_W + 16;

    localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(BLK_W - 1);
    localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(BLK_H - 1);
    localparam logic [HB_W-1:0]   HB_END    = HB_W'(H_BLOCKS);
    localparam logic [HB_W-1:0]   K_LAST    = HB_W'(H_BLOCKS - 1);
    localparam logic [5:0]        VB_END    = 6'(V_BLOCKS);
    localparam logic [PROD_W-1:0] RECIP_EXT = PROD_W'(RECIP);
    localparam logic [PROD_W-1:0] MEAN_MAX  = PROD_W'(255);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic              de_q, vs_q;
    logic [PX_W-1:0]   px_cnt_q, px_cnt_d;
    logic [HB_W-1:0]   hb_idx_q, hb_idx_d;
    logic [LN_W-1:0]   ln_cnt_q, ln_cnt_d;
    logic [5:0]        vb_idx_q, vb_idx_d;
    logic [SUM_W-1:0]  acc_q [H_BLOCKS];
    logic [SUM_W-1:0]  acc_d [H_BLOCKS];
    logic [SUM_W-1:0]  hold_q [H_BLOCKS];
    logic [SUM_W-1:0]  hold_d [H_BLOCKS];
    logic [HB_W-1:0]   k_q, k_d;
    logic [5:0]        row_q, row_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              s1_vld_q, s1_vld_d;
    logic [7:0]        mean_q, mean_d;
    logic              vld_q, vld_d;

    logic              vs_rise, eol;
    logic [PROD_W-1:0] shifted;

    assign vs_rise = vs_in & ~vs_q;
    assign eol     = ~de_in & de_q;
    assign shifted = prod_q >> SHIFT;

    always_comb begin
        state_d  = state_q;
        px_cnt_d = px_cnt_q;
        hb_idx_d = hb_idx_q;
        ln_cnt_d = ln_cnt_q;
        vb_idx_d = vb_idx_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        k_d      = k_q;
        row_d    = row_q;
        prod_d   = prod_q;
        s1_vld_d = 1'b0;
        mean_d   = mean_q;
        vld_d    = 1'b0;

        if (vs_rise) begin
            // Frame restart discards partial rows and anything still in flight.
            state_d  = IDLE;
            px_cnt_d = '0;
            hb_idx_d = '0;
            ln_cnt_d = '0;
            vb_idx_d = '0;
            k_d      = '0;
            for (int i = 0; i < H_BLOCKS; i++) acc_d[i] = '0;
        end else begin
            if (de_in && hb_idx_q < HB_END && vb_idx_q < VB_END) begin
                acc_d[hb_idx_q] = acc_q[hb_idx_q] + SUM_W'(y_in);
                if (px_cnt_q == PX_LAST) begin
                    px_cnt_d = '0;
                    hb_idx_d = hb_idx_q + 1'b1;
                end else begin
                    px_cnt_d = px_cnt_q + 1'b1;
                end
            end

            if (state_q == EMIT) begin
                prod_d   = PROD_W'(hold_q[k_q]) * RECIP_EXT;
                s1_vld_d = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            if (eol) begin
                px_cnt_d = '0;
                hb_idx_d = '0;
                if (vb_idx_q < VB_END) begin
                    if (ln_cnt_q == LN_LAST) begin
                        ln_cnt_d = '0;
                        hold_d   = acc_q;
                        for (int i = 0; i < H_BLOCKS; i++) acc_d[i] = '0;
                        row_d    = vb_idx_q;
                        vb_idx_d = vb_idx_q + 1'b1;
                        state_d  = EMIT;
                        k_d      = '0;
                    end else begin
                        ln_cnt_d = ln_cnt_q + 1'b1;
                    end
                end
            end

            vld_d = s1_vld_q;
            if (s1_vld_q) begin
                mean_d = (shifted > MEAN_MAX) ? 8'hFF : shifted[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            de_q     <= 1'b0;
            vs_q     <= 1'b0;
            px_cnt_q <= '0;
            hb_idx_q <= '0;
            ln_cnt_q <= '0;
            vb_idx_q <= '0;
            for (int i = 0; i < H_BLOCKS; i++) begin
                acc_q[i]  <= '0;
                hold_q[i] <= '0;
            end
            k_q      <= '0;
            row_q    <= '0;
            prod_q   <= '0;
            s1_vld_q <= 1'b0;
            mean_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            de_q     <= de_in;
            vs_q     <= vs_in;
            px_cnt_q <= px_cnt_d;
            hb_idx_q <= hb_idx_d;
            ln_cnt_q <= ln_cnt_d;
            vb_idx_q <= vb_idx_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
            k_q      <= k_d;
            row_q    <= row_d;
            prod_q   <= prod_d;
            s1_vld_q <= s1_vld_d;
            mean_q   <= mean_d;
            vld_q    <= vld_d;
        end
    end

    assign block_mean  = mean_q;
    assign data_vaild  = vld_q;
    assign block_v_cnt = row_q;

endmodule

// File: tb/tb_block_mean_calc.sv
// Scoreboard bench for block_mean_calc on a reduced geometry: expected block means
// come from plain averaging of each frame's pixel array and are checked as strobes arrive.
module tb_block_mean_calc;
    localparam int SHB = 2;
    localparam int SVB = 2;
    localparam int SBW = 4;
    localparam int SBH = 2;

    logic       clk;
    logic       rstn;
    logic       vs_in;
    logic       de_in;
    logic [7:0] y_in;
    logic [7:0] block_mean;
    logic       data_vaild;
    logic [5:0] block_v_cnt;

    typedef struct {
        int mean;
        int row;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    bit   mute;

    block_mean_calc #(
        .H_BLOCKS(SHB),
        .V_BLOCKS(SVB),
        .BLK_W   (SBW),
        .BLK_H   (SBH),
        .SUM_W   (16),
        .RECIP   (32),
        .SHIFT   (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .y_in       (y_in),
        .block_mean (block_mean),
        .data_vaild (data_vaild),
        .block_v_cnt(block_v_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // mode: 0 const 100, 1 left 255 / right 0, 2 ramp by pixel index, 3 random
    task automatic run_frame(input int mode, input int npx, input int nl,
                             input int stop_line, input bit coincident, input bit rst_mid);
        int pix[6][12];
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 12; x++)
                case (mode)
                    0:       pix[y][x] = 100;
                    1:       pix[y][x] = (x < SBW) ? 255 : 0;
                    2:       pix[y][x] = x;
                    default: pix[y][x] = int'($urandom_range(0, 255));
                endcase

        vs_in = 1'b0;
        cyc();
        vs_in = 1'b1;
        cyc();
        cyc();
        vs_in = 1'b0;
        repeat (4) cyc();

        for (int y = 0; y < nl; y++) begin
            bit row_done;
            bit kill;
            for (int x = 0; x < npx; x++) begin
                cyc();
                de_in = 1'b1;
                y_in  = 8'(pix[y][x]);
            end
            row_done = ((y + 1) % SBH == 0) && (y < SVB * SBH);
            kill     = (y == stop_line) && coincident;
            if (row_done && !kill && !mute) begin
                int r;
                r = y / SBH;
                for (int b = 0; b < SHB; b++) begin
                    int sum;
                    exp_t e;
                    sum = 0;
                    for (int yy = r * SBH; yy < (r + 1) * SBH; yy++)
                        for (int xx = b * SBW; xx < (b + 1) * SBW; xx++)
                            sum += pix[yy][xx];
                    e.mean = sum / (SBW * SBH);
                    if (e.mean > 255) e.mean = 255;
                    e.row = r;
                    sb.push_back(e);
                end
            end
            cyc();
            de_in = 1'b0;
            y_in  = 8'd0;
            if (kill) vs_in = 1'b1;
            if (rst_mid && y == stop_line) begin
                cyc();
                cyc();
                cyc();
                chk("strobe_before_reset", int'(data_vaild), 1);
                #2;
                rstn = 1'b0;
                #1;
                chk("async_rst_mean", int'(block_mean), 0);
                chk("async_rst_valid", int'(data_vaild), 0);
                chk("async_rst_vcnt", int'(block_v_cnt), 0);
                cyc();
                cyc();
                rstn = 1'b1;
                repeat (4) cyc();
                return;
            end
            repeat (6) cyc();
            if (y == stop_line) break;
        end
        repeat (8) cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mute   = 1'b0;
        rstn   = 1'b0;
        vs_in  = 1'b0;
        de_in  = 1'b0;
        y_in   = 8'd0;
        repeat (3) cyc();
        chk("reset_mean", int'(block_mean), 0);
        chk("reset_valid", int'(data_vaild), 0);
        chk("reset_vcnt", int'(block_v_cnt), 0);
        rstn = 1'b1;
        cyc();

        fork
            forever begin
                @(negedge clk);
                if (rstn && data_vaild && !mute) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_strobe", int'(block_mean), -1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("block_mean", int'(block_mean), e.mean);
                        chk("block_v_cnt", int'(block_v_cnt), e.row);
                    end
                end
            end
        join_none

        run_frame(0, 8, 4, -1, 1'b0, 1'b0);   // constant 100
        run_frame(1, 8, 4, -1, 1'b0, 1'b0);   // saturating left blocks
        run_frame(2, 8, 4, -1, 1'b0, 1'b0);   // ramp: means 1,5
        run_frame(2, 12, 6, -1, 1'b0, 1'b0);  // oversize lines and frame
        run_frame(3, 12, 6, -1, 1'b0, 1'b0);
        run_frame(3, 8, 4, 2, 1'b0, 1'b0);    // abort after first line of row 1
        run_frame(3, 8, 4, -1, 1'b0, 1'b0);   // must start clean at row 0
        run_frame(3, 8, 4, 3, 1'b1, 1'b0);    // vsync coincides with last-row trigger
        run_frame(0, 8, 4, -1, 1'b0, 1'b0);

        mute = 1'b1;
        run_frame(3, 8, 4, 1, 1'b0, 1'b1);    // reset during emission of row 0
        mute = 1'b0;
        run_frame(3, 8, 4, -1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            run_frame(3, int'($urandom_range(8, 12)), int'($urandom_range(4, 6)), -1, 1'b0, 1'b0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) cyc();
        chk("sb_drained", sb.size(), 0);
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_mean_calc.md
# block_mean_calc

Computes the average luma of each rectangular screen block for local-dimming backlight control. Sits directly upstream of the FIFO-to-LED stage, in the pixel clock domain. Consumes the active-video luma stream and emits one 8-bit mean per block, row of blocks at a time, with the block-row index. Output feeds the FIFO write port (`block_mean`, `data_vaild`, `block_v_cnt`).

## Interface
- `H_BLOCKS`, 8: blocks per block row.
- `V_BLOCKS`, 5: block rows per frame (H_BLOCKS*V_BLOCKS = 40 LEDs).
- `BLK_W`, 160: pixels per block horizontally.
- `BLK_H`, 144: lines per block vertically.
- `SUM_W`, 23: accumulator width, ≥ ceil(log2(255*BLK_W*BLK_H+1)).
- `RECIP`, 11651: round(2^SHIFT/(BLK_W*BLK_H)), 16-bit unsigned.
- `SHIFT`, 28: right shift applied after the reciprocal multiply.
- `clk`  in  1  pixel clock (pclk domain); all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `vs_in`  in  1  vertical sync, active high.
- `de_in`  in  1  data enable, active high during active pixels.
- `y_in`  in  8  pixel luma, valid when `de_in`=1.
- `block_mean`  out  8  block average.
- `data_vaild`  out  1  one-cycle strobe per `block_mean`.
- `block_v_cnt`  out  6  block-row index of the current output, 0..V_BLOCKS-1.

## Operation
- Counters: `px_cnt` (0..BLK_W-1), `hb_idx` (0..H_BLOCKS), `ln_cnt` (0..BLK_H-1), `vb_idx` (0..V_BLOCKS).
- `vs_in` rising edge: clear all counters and accumulators and abort any emission; nothing is output for a partial block row.
- Each `de_in`=1 cycle with `hb_idx`<H_BLOCKS and `vb_idx`<V_BLOCKS: `acc[hb_idx] += y_in`; advance `px_cnt`, and wrap it to `hb_idx`+1.
- Pixels beyond H_BLOCKS*BLK_W in a line are ignored. Lines beyond V_BLOCKS*BLK_H in a frame are ignored.
- `de_in` falling edge (end of line): zero `px_cnt` and `hb_idx`, then increment `ln_cnt`.
- If `ln_cnt`=BLK_H-1 at end of line:
  - Copy all `acc[]` into `hold[]` and clear `acc[]` in the same cycle.
  - Zero `ln_cnt`, latch `vb_idx` as the output row, increment `vb_idx`, and start emission.
- Emission FSM:
  - IDLE → EMIT on the end-of-block-row trigger.
  - EMIT walks k=0..H_BLOCKS-1, one per cycle, and returns to IDLE after k=H_BLOCKS-1.
- Arithmetic, per k:
  - Stage 1 registers `prod = hold[k]*RECIP` (SUM_W+16 bits).
  - Stage 2 outputs `block_mean = min(255, prod>>SHIFT)` with `data_vaild`=1.
- `block_v_cnt` carries the latched row index, constant for all H_BLOCKS strobes of that row.
- Accumulation of the next line proceeds concurrently with emission because `hold[]` decouples them.
- A vsync-abort mid-emission kills the in-flight pipeline stages: no further `data_vaild` is asserted.

## Timing
- Reset values: `block_mean`=0, `data_vaild`=0, `block_v_cnt`=0, all counters/`acc`/`hold`=0, FSM=IDLE.
- Edge detection uses `de_in`/`vs_in` registered by one cycle.
- The end-of-line action occurs on the cycle after the first `de_in`=0 cycle.
- Latency from that end-of-line cycle:
  - first `data_vaild` 2 cycles later;
  - H_BLOCKS consecutive strobes;
  - `data_vaild` low otherwise.
- Output is in block order left→right, rows top→bottom; exactly H_BLOCKS*V_BLOCKS strobes per complete frame.
- The next trigger cannot occur during emission, since each line has ≥ BLK_W*H_BLOCKS cycles > H_BLOCKS.
- `vs_in` rise coincident with the last-line trigger: vsync wins and no row is emitted.
- `de_in`=0 cycles within a line are not allowed. Each `de_in` fall is treated as end of line.

## Test plan
- Small config (H_BLOCKS=2, V_BLOCKS=2, BLK_W=4, BLK_H=2, SHIFT=8, RECIP=32), constant `y_in`=100 over a full frame → 4 strobes, all `block_mean`=100; `block_v_cnt`=0,0,1,1.
- Same config, left blocks `y_in`=255, right blocks 0 → row means 255,0 for both rows; 255 is not exceeded, confirming saturation logic.
- Same config, ramp `y_in`=px index 0..7 per line → row means 1,5 (sum 12→1.5 truncated to 1; sum 44→5.5 truncated to 5).
- Lines of 12 pixels and 6 lines per frame → extra pixels/lines ignored; still exactly 4 strobes with values unchanged.
- `vs_in` pulse after the first line of block row 1 → only row 0 is emitted; the next frame starts at `block_v_cnt`=0 with clean accumulators.
- Assert `rstn`=0 during emission → all outputs 0 immediately (async); after release, the first full frame yields correct means.
